debounce_pulse: RTL and testbench

Conditions a raw, asynchronous pushbutton or switch input into clean single-cycle event pulses for `simple_counter`'s `evt_in`. It synchronizes the input, requires a configurable run of consecutive stable samples before accepting a level change, and emits one `evt_out` pulse per accepted rising edge. It sits directly upstream of the counter, between board I/O and `evt_in`.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/sync_2ff.sv | 32 +++
 rtl/debounce_pulse.sv | 134 +++++++++++++
 tb/tb_debounce_pulse.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and defaults for the debounce_pulse block.
//   state_t                 : debounce FSM state (2-bit enum)
//   DEBOUNCE_CYCLES_DEFAULT : default stable-sample count (10 ms at 100 MHz)
// The counter width is derived from the parameter inside debounce_pulse.
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous board input.
// Ports:
//   clk_in : destination clock
//   rst_in : asynchronous, active-low reset (both flops clear to 0)
//   d_in   : asynchronous input level
//   q_out  : synchronized level, two clock edges after d_in
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
// Turns a raw pushbutton/switch level into a debounced level and a clean
// single-cycle event pulse per accepted rising edge.
//
// Optional feature macro: DEBOUNCE_FALL_EVT_EN
//   defined   -> evt_out also pulses on each accepted falling edge
//   undefined -> evt_out pulses on accepted rising edges only (default)
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to accept
//                     a level change (>= 2)
// Ports:
//   clk_in    : system clock
//   rst_in    : asynchronous, active-low reset
//   raw_in    : raw asynchronous button/switch level
//   level_out : debounced level (registered)
//   evt_out   : one-cycle event pulse (registered)
//   state_out : current FSM state, for debug/observation
//
// Handshake: none; evt_out is a fire-and-forget strobe, high for exactly one
// clock per accepted edge, and never high on two consecutive cycles.
// -----------------------------------------------------------------------------
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       raw_in,
    output logic       level_out,
    output logic       evt_out,
    output logic [1:0] state_out
);

    // cnt only ever needs to reach DEBOUNCE_CYCLES-1, which always fits in
    // $clog2(DEBOUNCE_CYCLES) bits, so it can never wrap.
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             evt_q, evt_d;

    sync_2ff u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (raw_in),
        .q_out  (s)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            evt_q   <= evt_d;
        end
    end

    // A sample that disagrees with the stable level starts the count at 1
    // (that sample is the first of the run); any agreeing sample during a
    // wait aborts back to the stable state with the count cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        evt_d   = 1'b0;
        case (state_q)
            LOW: begin
                cnt_d = '0;
                if (s) begin
                    state_d = RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            FALL_WAIT: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef DEBOUNCE_FALL_EVT_EN
                    evt_d   = 1'b1;
`else
                    evt_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_out = level_q;
    assign evt_out   = evt_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_debounce_pulse
// Bench for debounce_pulse with DEBOUNCE_CYCLES=4 and a 10 ns clock.
// Directed timing scenarios plus a randomized run checked against a reference
// model that tracks the accepted level and the length of the current run of
// synchronized samples disagreeing with it. Accepted events are tallied in
// evt_count, standing in for a downstream event counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_pulse;

    localparam int N = 4;

`ifdef DEBOUNCE_FALL_EVT_EN
    localparam int PRESS_RELEASE_EVTS = 2;
    localparam bit FALL_EVT = 1'b1;
`else
    localparam int PRESS_RELEASE_EVTS = 1;
    localparam bit FALL_EVT = 1'b0;
`endif

    logic       clk_in;
    logic       rst_in;
    logic       raw_in;
    logic       level_out;
    logic       evt_out;
    logic [1:0] state_out;

    int tests_run = 0;
    int failed    = 0;
    int evt_count = 0;

    debounce_pulse #(.DEBOUNCE_CYCLES(N)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (raw_in),
        .level_out (level_out),
        .evt_out   (evt_out),
        .state_out (state_out)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- event tally ----------------
    always @(negedge clk_in) begin
        if (evt_out === 1'b1) evt_count <= evt_count + 1;
    end

    // ---------------- reference model ----------------
    // s is raw_in seen two edges late. The model keeps the accepted level and
    // how many consecutive samples have disagreed with it; N in a row flips it.
    logic [1:0] hist;
    logic       level_m;
    logic       evt_m;
    int         run;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hist    <= 2'b00;
            level_m <= 1'b0;
            evt_m   <= 1'b0;
            run     <= 0;
        end else begin
            hist  <= {hist[0], raw_in};
            evt_m <= 1'b0;
            if (hist[1] != level_m) begin
                if (run + 1 == N) begin
                    level_m <= hist[1];
                    evt_m   <= hist[1] ? 1'b1 : FALL_EVT;
                    run     <= 0;
                end else begin
                    run <= run + 1;
                end
            end else begin
                run <= 0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle_low();
        raw_in = 1'b0;
        repeat (12) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int c0;
        rst_in = 1'b0;
        raw_in = 1'b0;
        #1;
        tests_run++;
        if (level_out !== 1'b0 || evt_out !== 1'b0 || state_out !== 2'd0) begin
            failed++;
            $display("FAIL reset_values: level=%b evt=%b state=%0d, want 0 0 0",
                     level_out, evt_out, state_out);
        end
        tick();
        tick();
        #2 rst_in = 1'b1;
        c0 = evt_count;
        for (int k = 0; k < 20; k++) begin
            tick();
            tests_run++;
            if (evt_out !== 1'b0 || level_out !== 1'b0) begin
                failed++;
                $display("FAIL reset_idle cyc %0d: evt=%b level=%b, want 0 0",
                         k, evt_out, level_out);
            end
        end
        tick();
        tests_run++;
        if (evt_count - c0 != 0) begin
            failed++;
            $display("FAIL reset_idle_count: got %0d events, want 0", evt_count - c0);
        end
    endtask

    task automatic test_clean_press();
        int c0;
        c0 = evt_count;
        raw_in = 1'b1;                   // before edge 0
        for (int k = 0; k <= 8; k++) begin
            tick();                      // just after edge k
            tests_run++;
            if (evt_out !== (k == 5) || level_out !== (k >= 5)) begin
                failed++;
                $display("FAIL clean_press edge %0d: evt=%b level=%b, want %b %b",
                         k, evt_out, level_out, (k == 5), (k >= 5));
            end
        end
        tick();
        tests_run++;
        if (evt_count - c0 != 1) begin
            failed++;
            $display("FAIL clean_press_count: got %0d, want 1", evt_count - c0);
        end
        settle_low();
        tests_run++;
        if (level_out !== 1'b0) begin
            failed++;
            $display("FAIL clean_release_level: got %b, want 0", level_out);
        end
    endtask

    task automatic test_bounce();
        int c0;
        c0 = evt_count;
        for (int b = 0; b < 4; b++) begin
            raw_in = (b % 2 == 0);
            tick();
            tick();
        end
        raw_in = 1'b1;                   // final rise, before edge 0
        for (int k = 0; k <= 9; k++) begin
            tick();
            tests_run++;
            if (evt_out !== (k == 5)) begin
                failed++;
                $display("FAIL bounce edge %0d: evt=%b, want %b", k, evt_out, (k == 5));
            end
        end
        tick();
        tests_run++;
        if (evt_count - c0 != 1 || level_out !== 1'b1) begin
            failed++;
            $display("FAIL bounce_count: got %0d level=%b, want 1 level=1",
                     evt_count - c0, level_out);
        end
        settle_low();
    endtask

    task automatic test_short_glitch();
        int c0;
        c0 = evt_count;
        raw_in = 1'b1;
        repeat (3) tick();
        raw_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            tests_run++;
            if (evt_out !== 1'b0 || level_out !== 1'b0) begin
                failed++;
                $display("FAIL glitch cyc %0d: evt=%b level=%b, want 0 0",
                         k, evt_out, level_out);
            end
        end
        tests_run++;
        if (evt_count - c0 != 0) begin
            failed++;
            $display("FAIL glitch_count: got %0d, want 0", evt_count - c0);
        end
    endtask

    task automatic test_mid_reset();
        raw_in = 1'b1;                   // before edge 0
        repeat (4) tick();               // after edge 3: RISE_WAIT, cnt=2
        tests_run++;
        if (state_out !== 2'd1) begin
            failed++;
            $display("FAIL mid_reset_pre_state: got %0d, want 1", state_out);
        end
        rst_in = 1'b0;
        #1;
        tests_run++;
        if (level_out !== 1'b0 || evt_out !== 1'b0 || state_out !== 2'd0) begin
            failed++;
            $display("FAIL mid_reset_values: level=%b evt=%b state=%0d, want 0 0 0",
                     level_out, evt_out, state_out);
        end
        tick();
        rst_in = 1'b1;                   // release; next edge is edge 0
        for (int k = 0; k <= 8; k++) begin
            tick();
            tests_run++;
            if (evt_out !== (k == 5)) begin
                failed++;
                $display("FAIL mid_reset edge %0d: evt=%b, want %b", k, evt_out, (k == 5));
            end
        end
        settle_low();
    endtask

    task automatic test_fall_event();
        int c0;
        c0 = evt_count;
        raw_in = 1'b1;
        repeat (10) tick();
        raw_in = 1'b0;
        repeat (20) tick();
        tests_run++;
        if (evt_count - c0 != PRESS_RELEASE_EVTS || level_out !== 1'b0) begin
            failed++;
            $display("FAIL fall_event_count: got %0d level=%b, want %0d level=0",
                     evt_count - c0, level_out, PRESS_RELEASE_EVTS);
        end
    endtask

    task automatic test_random();
        logic prev_evt;
        prev_evt = 1'b0;
        for (int r = 0; r < 150; r++) begin
            raw_in = 1'($urandom_range(0, 1));
            for (int k = $urandom_range(1, 9); k > 0; k--) begin
                tick();
                tests_run++;
                if (level_out !== level_m || evt_out !== evt_m) begin
                    failed++;
                    $display("FAIL random run %0d: level=%b evt=%b, want %b %b",
                             r, level_out, evt_out, level_m, evt_m);
                end
                tests_run++;
                if (prev_evt === 1'b1 && evt_out === 1'b1) begin
                    failed++;
                    $display("FAIL random_double_pulse run %0d: evt=1 twice, want single", r);
                end
                prev_evt = evt_out;
            end
        end
        settle_low();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_glitch();
        test_mid_reset();
        test_fall_event();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
